// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter.
package wb_pkg;

  localparam int REG_AW       = 5;
  localparam int DEFAULT_XLEN = 32;

  typedef struct packed {
    logic [REG_AW-1:0]       rd;
    logic [DEFAULT_XLEN-1:0] wd;
  } wb_entry_t;

  // One-hot register mask; x0 never shows up as a pending target.
  function automatic logic [31:0] reg_onehot(input logic [REG_AW-1:0] r);
    return (32'd1 << r) & ~32'd1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers and per-slot valid flags.
import wb_pkg::*;

module wb_fifo #(
  parameter type entry_t = wb_entry_t,
  parameter int  DEPTH   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  entry_t                       wdata,
  output entry_t                       rdata,
  output logic                         full,
  output logic                         empty,
  output logic [DEPTH-1:0]             entry_valid,
  output logic [DEPTH-1:0][REG_AW-1:0] entry_rd
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] count_s;
  logic [AW-1:0] off_s;
  logic          do_push_s;
  logic          do_pop_s;
  entry_t        mem_r [DEPTH];

  assign full      = (wr_ptr_r[PW-1] != rd_ptr_r[PW-1]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign count_s   = wr_ptr_r - rd_ptr_r;
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign rdata     = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= wdata;
  end

  // A slot is live when its distance from the read pointer is below the fill count
  always_comb begin
    entry_valid = '0;
    entry_rd    = '0;
    off_s       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off_s          = AW'(i) - rd_ptr_r[AW-1:0];
      entry_valid[i] = ({1'b0, off_s} < count_s);
      entry_rd[i]    = mem_r[i].rd;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: queued loads beat ALU results for the single register-file write port.
// Optional feature: define WB_PENDING_EN to add the per-register pending-write mask output.
import wb_pkg::*;

module wb_arbiter #(
  parameter int XLEN     = DEFAULT_XLEN,
  parameter int LD_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [4:0]        alu_rd,
  input  logic [XLEN-1:0]   alu_wd,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [4:0]        ld_rd,
  input  logic [XLEN-1:0]   ld_wd,
  output logic              ld_ready,
  output logic              rf_we,
  output logic [4:0]        rf_rd,
  output logic [XLEN-1:0]   rf_wd,
  output logic              busy
`ifdef WB_PENDING_EN
  ,
  output logic [31:0]       pending
`endif
);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wd;
  } entry_t;

  entry_t                          ld_entry_s;
  entry_t                          head_s;
  logic                            fifo_full_s;
  logic                            fifo_empty_s;
  logic                            push_s;
  logic                            pop_s;
  logic [LD_DEPTH-1:0]             entry_valid_s;
  logic [LD_DEPTH-1:0][REG_AW-1:0] entry_rd_s;
  logic                            win_valid_s;
  logic [REG_AW-1:0]               win_rd_s;
  logic [XLEN-1:0]                 win_wd_s;
  logic                            rf_we_r;
  logic [REG_AW-1:0]               rf_rd_r;
  logic [XLEN-1:0]                 rf_wd_r;

  assign ld_entry_s.rd = ld_rd;
  assign ld_entry_s.wd = ld_wd;

  // ld_ready comes from registered fullness only, so a same-cycle pop never opens it
  assign ld_ready  = !fifo_full_s && !rst;
  assign alu_ready = fifo_empty_s && !rst;
  assign push_s    = ld_valid && ld_ready;
  assign pop_s     = !fifo_empty_s && !rst;

  wb_fifo #(
    .entry_t (entry_t),
    .DEPTH   (LD_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push_s),
    .pop         (pop_s),
    .wdata       (ld_entry_s),
    .rdata       (head_s),
    .full        (fifo_full_s),
    .empty       (fifo_empty_s),
    .entry_valid (entry_valid_s),
    .entry_rd    (entry_rd_s)
  );

  // Pick this cycle's writer: FIFO head first, then the ALU
  always_comb begin
    win_valid_s = 1'b0;
    win_rd_s    = '0;
    win_wd_s    = '0;
    if (!fifo_empty_s) begin
      win_valid_s = 1'b1;
      win_rd_s    = head_s.rd;
      win_wd_s    = head_s.wd;
    end else if (alu_valid) begin
      win_valid_s = 1'b1;
      win_rd_s    = alu_rd;
      win_wd_s    = alu_wd;
    end else begin
      win_valid_s = 1'b0;
    end
  end

  // Write register; x0 winners are consumed without raising the enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_r <= 1'b0;
      rf_rd_r <= '0;
      rf_wd_r <= '0;
    end else if (win_valid_s && (win_rd_s != 5'd0)) begin
      rf_we_r <= 1'b1;
      rf_rd_r <= win_rd_s;
      rf_wd_r <= win_wd_s;
    end else begin
      rf_we_r <= 1'b0;
    end
  end

  assign rf_we = rf_we_r;
  assign rf_rd = rf_rd_r;
  assign rf_wd = rf_wd_r;
  assign busy  = !fifo_empty_s || rf_we_r;

`ifdef WB_PENDING_EN
  logic [31:0] pending_s;

  // Targets of queued loads plus the write in flight
  always_comb begin
    pending_s = '0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      if (entry_valid_s[i]) begin
        pending_s = pending_s | reg_onehot(entry_rd_s[i]);
      end else begin
        pending_s = pending_s;
      end
    end
    if (rf_we_r) begin
      pending_s = pending_s | reg_onehot(rf_rd_r);
    end else begin
      pending_s = pending_s;
    end
  end

  assign pending = pending_s;
`else
  logic [LD_DEPTH-1:0]             unused_valid_s;
  logic [LD_DEPTH-1:0][REG_AW-1:0] unused_rd_s;

  assign unused_valid_s = entry_valid_s;
  assign unused_rd_s    = entry_rd_s;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: queue-based reference model plus directed literal checks.
module tb_wb_arbiter;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_wd;
  logic            alu_ready;
  logic            ld_valid;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_wd;
  logic            ld_ready;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wd;
  logic            busy;
`ifdef WB_PENDING_EN
  logic [31:0]     pending;
`endif

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(XLEN), .LD_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_wd    (alu_wd),
    .alu_ready (alu_ready),
    .ld_valid  (ld_valid),
    .ld_rd     (ld_rd),
    .ld_wd     (ld_wd),
    .ld_ready  (ld_ready),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wd     (rf_wd),
    .busy      (busy)
`ifdef WB_PENDING_EN
    ,
    .pending   (pending)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a queue of waiting loads and the expected write-port state
  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] wd;
  } ent_t;

  ent_t            ldq[$];
  logic            m_we = 1'b0;
  logic [4:0]      m_rd = 5'd0;
  logic [XLEN-1:0] m_wd = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ldq.delete();
      m_we = 1'b0;
      m_rd = 5'd0;
      m_wd = '0;
    end else begin
      ent_t w;
      bit   have;
      bit   accept_ld;
      accept_ld = ld_valid && (ldq.size() < DEPTH);
      have = 1'b0;
      if (ldq.size() > 0) begin
        w = ldq.pop_front();
        have = 1'b1;
      end else if (alu_valid) begin
        w.rd = alu_rd;
        w.wd = alu_wd;
        have = 1'b1;
      end
      if (have && w.rd != 5'd0) begin
        m_we = 1'b1;
        m_rd = w.rd;
        m_wd = w.wd;
      end else begin
        m_we = 1'b0;
      end
      if (accept_ld) ldq.push_back('{ld_rd, ld_wd});
    end
  end

  // Compare every cycle away from the active edge
  always @(negedge clk) begin
    logic [31:0] exp_pend;
    check("alu_ready", alu_ready, !rst && ldq.size() == 0);
    check("ld_ready", ld_ready, !rst && ldq.size() < DEPTH);
    check("rf_we", rf_we, m_we);
    if (m_we) begin
      check("rf_rd", rf_rd, m_rd);
      check("rf_wd", rf_wd, m_wd);
    end
    check("busy", busy, (ldq.size() != 0) || m_we);
    exp_pend = 32'd0;
    foreach (ldq[i]) exp_pend[ldq[i].rd] = 1'b1;
    if (m_we) exp_pend[m_rd] = 1'b1;
    exp_pend[0] = 1'b0;
`ifdef WB_PENDING_EN
    check("pending", pending, exp_pend);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_wd = '0;
    ld_valid = 1'b0;  ld_rd = 5'd0;  ld_wd = '0;
    tick();
    tick();
    check("rst_rf_we", rf_we, 1'b0);
    check("rst_rf_rd", rf_rd, 5'd0);
    check("rst_rf_wd", rf_wd, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_ld_ready", ld_ready, 1'b0);
    check("rst_alu_ready", alu_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("rel_ld_ready", ld_ready, 1'b1);
    check("rel_alu_ready", alu_ready, 1'b1);

    // ALU only
    alu_valid = 1'b1; alu_rd = 5'd5; alu_wd = 32'h1234;
    tick(); idle();
    check("alu_we", rf_we, 1'b1);
    check("alu_rd", rf_rd, 5'd5);
    check("alu_wd", rf_wd, 32'h1234);
    tick();
    check("alu_we_off", rf_we, 1'b0);
    check("hold_rd", rf_rd, 5'd5);
    check("hold_wd", rf_wd, 32'h1234);

    // Load and ALU together: ALU first, load next cycle
    ld_valid = 1'b1; ld_rd = 5'd3; ld_wd = 32'hAA;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_wd = 32'hBB;
    tick(); idle();
    check("mix_rd_alu", rf_rd, 5'd4);
    check("mix_wd_alu", rf_wd, 32'hBB);
    check("mix_alu_ready_lo", alu_ready, 1'b0);
    tick();
    check("mix_rd_ld", rf_rd, 5'd3);
    check("mix_wd_ld", rf_wd, 32'hAA);
    check("mix_we_ld", rf_we, 1'b1);
    tick();
    check("mix_we_off", rf_we, 1'b0);

    // Three back-to-back loads retire in order on consecutive cycles
    ld_valid = 1'b1; ld_rd = 5'd10; ld_wd = 32'h1001;
    tick();
    ld_rd = 5'd11; ld_wd = 32'h1002;
    tick();
    check("seq1_rd", rf_rd, 5'd10);
    ld_rd = 5'd12; ld_wd = 32'h1003;
    tick(); idle();
    check("seq2_rd", rf_rd, 5'd11);
    tick();
    check("seq3_rd", rf_rd, 5'd12);
    check("seq3_wd", rf_wd, 32'h1003);
    tick();
    check("seq_we_off", rf_we, 1'b0);

    // x0 writes are consumed silently
    alu_valid = 1'b1; alu_rd = 5'd0; alu_wd = 32'hFFFF;
    #1;
    check("x0_alu_ready", alu_ready, 1'b1);
    tick(); idle();
    check("x0_alu_we", rf_we, 1'b0);
    check("x0_alu_busy", busy, 1'b0);
    ld_valid = 1'b1; ld_rd = 5'd0; ld_wd = 32'h5;
    tick(); idle();
    check("x0_ld_busy", busy, 1'b1);
    tick();
    check("x0_ld_we", rf_we, 1'b0);
    check("x0_ld_busy_off", busy, 1'b0);

    // Reset mid-operation with a write in flight and a load queued
    ld_valid = 1'b1; ld_rd = 5'd20; ld_wd = 32'h55;
    alu_valid = 1'b1; alu_rd = 5'd21; alu_wd = 32'h66;
    tick(); idle();
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_we", rf_we, 1'b0);
    check("mid_rst_rd", rf_rd, 5'd0);
    check("mid_rst_wd", rf_wd, 32'd0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ld_ready", ld_ready, 1'b0);
    check("mid_rst_alu_ready", alu_ready, 1'b0);
`ifdef WB_PENDING_EN
    check("mid_rst_pending", pending, 32'd0);
`endif
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_ld_ready", ld_ready, 1'b1);
    check("post_rst_alu_ready", alu_ready, 1'b1);
    tick();
    check("post_rst_we", rf_we, 1'b0);
    check("post_rst_busy", busy, 1'b0);

`ifdef WB_PENDING_EN
    // Pending bit follows a load from push until its write has issued
    ld_valid = 1'b1; ld_rd = 5'd7; ld_wd = 32'h77;
    check("pend7_before", pending[7], 1'b0);
    tick(); idle();
    check("pend7_queued", pending[7], 1'b1);
    tick();
    check("pend7_writing", pending[7], 1'b1);
    check("pend7_we", rf_we, 1'b1);
    tick();
    check("pend7_clear", pending[7], 1'b0);
`endif

    // Random traffic checked by the model
    for (int n = 0; n < 60; n++) begin
      alu_valid = 1'($urandom_range(0, 1));
      alu_rd    = 5'($urandom_range(0, 31));
      alu_wd    = $urandom;
      ld_valid  = 1'($urandom_range(0, 1));
      ld_rd     = 5'($urandom_range(0, 31));
      ld_wd     = $urandom;
      tick();
    end
    idle();
    repeat (4) tick();
    check("drain_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
